// File: rtl/sprite_fetch_sched_if.sv
// Sprite ROM port and aligned pixel output bundle for sprite_fetch_sched.
// master: the scheduler (drives ROM address and pixel outputs, receives ROM data).
// slave:  the ROM/palette side (returns ROM data, consumes pixel outputs).
interface sprite_fetch_sched_if #(
  parameter int unsigned NUM_SPR = 4,
  parameter int unsigned ADDR_W  = 14
);
  localparam int unsigned ID_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic              pix_valid;
  logic [3:0]        pix_index;
  logic [ID_W-1:0]   pix_id;
  logic              blank_d;

  modport master (
    output rom_addr, pix_valid, pix_index, pix_id, blank_d,
    input  rom_q
  );

  modport slave (
    input  rom_addr, pix_valid, pix_index, pix_id, blank_d,
    output rom_q
  );
endinterface

// File: rtl/sprite_fetch_sched.sv
// Per-pixel scheduler for the shared sprite ROM port.
// Picks the highest-priority (lowest index) enabled sprite covering DrawX/DrawY,
// issues the ROM address (rotation-frame bank + texel), and aligns the returned
// palette index with blank. Fixed latency of 3 clocks, one pixel per clock.
// Sprite inputs are shadowed on frame_start so mid-frame changes never tear.
// Optional: define SPR_COLLIDE_EN to add the per-frame collide output.
module sprite_fetch_sched #(
  parameter int unsigned NUM_SPR = 4,
  parameter int unsigned SPR_W   = 32,
  parameter int unsigned SPR_H   = 32,
  parameter int unsigned FRAME_W = 4,
  parameter int unsigned ADDR_W  = 14
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       blank,
  input  logic                       frame_start,
  input  logic [NUM_SPR-1:0]         spr_en,
  input  logic [NUM_SPR*10-1:0]      spr_x,
  input  logic [NUM_SPR*10-1:0]      spr_y,
  input  logic [NUM_SPR*FRAME_W-1:0] spr_frame,
  sprite_fetch_sched_if.master       bus
`ifdef SPR_COLLIDE_EN
  ,
  output logic [NUM_SPR-1:0]         collide
`endif
);

  localparam int unsigned ID_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int unsigned XB   = $clog2(SPR_W);
  localparam int unsigned YB   = $clog2(SPR_H);

  logic [NUM_SPR-1:0]         sh_en;
  logic [NUM_SPR*10-1:0]      sh_x;
  logic [NUM_SPR*10-1:0]      sh_y;
  logic [NUM_SPR*FRAME_W-1:0] sh_frame;

  logic [9:0]         dx_c [NUM_SPR];
  logic [9:0]         dy_c [NUM_SPR];
  logic [NUM_SPR-1:0] hit_c;
  logic               any_hit_c;
  logic [ID_W-1:0]    win_id_c;
  logic [FRAME_W-1:0] win_frame_c;
  logic [XB-1:0]      win_dx_c;
  logic [YB-1:0]      win_dy_c;
  logic               pix_valid_c;

  logic [ADDR_W-1:0]  rom_addr_q;
  logic               s1_hit, s2_hit;
  logic [ID_W-1:0]    s1_id, s2_id;
  logic               blank_dly1, blank_dly2;
  logic               pix_valid_q;
  logic [3:0]         pix_index_q;
  logic [ID_W-1:0]    pix_id_q;
  logic               blank_d_q;

  // Shadow the live sprite state once per frame
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_en    <= '0;
      sh_x     <= '0;
      sh_y     <= '0;
      sh_frame <= '0;
    end else if (frame_start) begin
      sh_en    <= spr_en;
      sh_x     <= spr_x;
      sh_y     <= spr_y;
      sh_frame <= spr_frame;
    end
  end

  // Box test per sprite; 10-bit wrap makes off-screen/negative positions miss naturally
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < int'(NUM_SPR); i++) begin
      dx_c[i]  = DrawX - sh_x[10*i +: 10];
      dy_c[i]  = DrawY - sh_y[10*i +: 10];
      hit_c[i] = sh_en[i] & (dx_c[i] < 10'(SPR_W)) & (dy_c[i] < 10'(SPR_H));
    end
  end

  // Fixed-priority winner select: lowest index wins
  always_comb begin
    any_hit_c   = 1'b0;
    win_id_c    = '0;
    win_frame_c = '0;
    win_dx_c    = '0;
    win_dy_c    = '0;
    for (int i = 0; i < int'(NUM_SPR); i++) begin
      if (hit_c[i] && !any_hit_c) begin
        any_hit_c   = 1'b1;
        win_id_c    = ID_W'(i);
        win_frame_c = sh_frame[FRAME_W*i +: FRAME_W];
        win_dx_c    = dx_c[i][XB-1:0];
        win_dy_c    = dy_c[i][YB-1:0];
      end
    end
  end

  // Stage 0 -> 1 address register (holds on miss) and stage 1 -> 2 delay line
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      s1_hit     <= 1'b0;
      s1_id      <= '0;
      s2_hit     <= 1'b0;
      s2_id      <= '0;
      blank_dly1 <= 1'b0;
      blank_dly2 <= 1'b0;
    end else begin
      if (any_hit_c) begin
        rom_addr_q <= ADDR_W'({win_frame_c, win_dy_c, win_dx_c});
      end
      s1_hit     <= any_hit_c;
      s1_id      <= win_id_c;
      s2_hit     <= s1_hit;
      s2_id      <= s1_id;
      blank_dly1 <= blank;
      blank_dly2 <= blank_dly1;
    end
  end

  // Index 0 is transparent; no fall-through to lower-priority sprites
  assign pix_valid_c = s2_hit & (bus.rom_q != 4'd0) & blank_dly2;

  // Output register aligned with delayed blank
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_q <= 1'b0;
      pix_index_q <= '0;
      pix_id_q    <= '0;
      blank_d_q   <= 1'b0;
    end else begin
      pix_valid_q <= pix_valid_c;
      pix_index_q <= pix_valid_c ? bus.rom_q : 4'd0;
      pix_id_q    <= s2_id;
      blank_d_q   <= blank_dly2;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_index = pix_index_q;
  assign bus.pix_id    = pix_id_q;
  assign bus.blank_d   = blank_d_q;

`ifdef SPR_COLLIDE_EN
  logic [NUM_SPR-1:0] coll_c;
  logic [NUM_SPR-1:0] coll_acc;

  // A sprite collides when its box hit coincides with any other hit in active video
  always_comb begin
    coll_c = '0;
    for (int i = 0; i < int'(NUM_SPR); i++) begin
      coll_c[i] = blank & hit_c[i] & (|(hit_c & ~(NUM_SPR'(1) << i)));
    end
  end

  // Sticky per-frame accumulator, published and cleared on frame_start
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_acc <= '0;
      collide  <= '0;
    end else if (frame_start) begin
      collide  <= coll_acc;
      coll_acc <= '0;
    end else begin
      coll_acc <= coll_acc | coll_c;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Scoreboard bench for sprite_fetch_sched: the driver pushes hand-computed
// expectations (ROM address at t+1, pixel outputs at t+3) and a negedge monitor
// pops and compares them. The bench models the ROM as q = addr[3:0] ^ 2.
module tb_sprite_fetch_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start;
  logic [3:0]  spr_en;
  logic [39:0] spr_x, spr_y;
  logic [15:0] spr_frame;
`ifdef SPR_COLLIDE_EN
  logic [3:0]  collide;
`endif

  sprite_fetch_sched_if #(.NUM_SPR(4), .ADDR_W(14)) bus ();

  sprite_fetch_sched dut (
    .vga_clk     (clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .spr_en      (spr_en),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_frame   (spr_frame),
    .bus         (bus)
`ifdef SPR_COLLIDE_EN
    ,
    .collide     (collide)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous 1-cycle ROM
  initial bus.rom_q = 4'd0;
  always @(posedge clk) bus.rom_q <= bus.rom_addr[3:0] ^ 4'd2;

  typedef struct {
    int          due;
    int          tag;
    logic [13:0] addr;
  } addr_exp_t;

  typedef struct {
    int       due;
    int       tag;
    logic     v;
    logic [3:0] idx;
    int       id;
    logic     bd;
  } pix_exp_t;

  addr_exp_t aq[$];
  pix_exp_t  pq[$];
  addr_exp_t a_e;
  pix_exp_t  p_e;
  int cyc = 0;
  int vec = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare whatever expectation falls due this cycle
  always @(negedge clk) begin
    if (aq.size() > 0 && aq[0].due == cyc) begin
      a_e = aq.pop_front();
      chk($sformatf("v%0d rom_addr", a_e.tag), int'(bus.rom_addr), int'(a_e.addr));
    end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      p_e = pq.pop_front();
      chk($sformatf("v%0d pix_valid", p_e.tag), int'(bus.pix_valid), int'(p_e.v));
      chk($sformatf("v%0d pix_index", p_e.tag), int'(bus.pix_index), int'(p_e.idx));
      chk($sformatf("v%0d blank_d", p_e.tag), int'(bus.blank_d), int'(p_e.bd));
      if (p_e.id >= 0)
        chk($sformatf("v%0d pix_id", p_e.tag), int'(bus.pix_id), p_e.id);
    end
  end

  // Drive one pixel and queue its expected address / output (eid<0: id not checked)
  task automatic step(input bit fs, input int x, input int y, input bit b,
                      input int ea, input bit ev, input int ei, input int eid);
    addr_exp_t ae;
    pix_exp_t  pe;
    @(posedge clk); #1;
    frame_start = fs;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    vec++;
    ae.due = cyc + 1; ae.tag = vec; ae.addr = 14'(ea);
    pe.due = cyc + 3; pe.tag = vec; pe.v = ev; pe.idx = 4'(ei); pe.id = eid; pe.bd = b;
    aq.push_back(ae);
    pq.push_back(pe);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rom_addr"},  int'(bus.rom_addr), 0);
    chk({tag, " pix_valid"}, int'(bus.pix_valid), 0);
    chk({tag, " pix_index"}, int'(bus.pix_index), 0);
    chk({tag, " pix_id"},    int'(bus.pix_id), 0);
    chk({tag, " blank_d"},   int'(bus.blank_d), 0);
`ifdef SPR_COLLIDE_EN
    chk({tag, " collide"},   int'(collide), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
    spr_en = '0; spr_x = '0; spr_y = '0; spr_frame = '0;
    idle(3);
    chk_reset_state("reset");

    // Sprite 0 at (100,50), frame 3
    spr_en = 4'b0001;
    spr_x[9:0] = 10'd100; spr_y[9:0] = 10'd50; spr_frame[3:0] = 4'd3;
    @(negedge clk) reset_n = 1'b1;

    step(0, 105, 52, 1,    0, 0,  0, -1); // shadow still empty
    step(1,   0,  0, 0,    0, 0,  0, -1); // frame_start loads shadow
    step(0, 105, 52, 1, 3141, 1,  7,  0);
    step(0, 100, 50, 1, 3072, 1,  2,  0);
    step(0, 131, 81, 1, 4095, 1, 13,  0);
    step(0, 132, 50, 1, 4095, 0,  0, -1); // right edge miss, addr holds
    step(0,  99, 50, 1, 4095, 0,  0, -1); // left of box wraps to a miss
    step(0, 105, 52, 0, 3141, 0,  0,  0); // blank=0 forces pix_valid low
    step(0, 102, 50, 1, 3074, 0,  0,  0); // transparent texel

    // Live move mid-frame has no effect until frame_start
    spr_x[9:0] = 10'd300;
    step(0, 105, 52, 1, 3141, 1,  7,  0);
    step(0, 305, 52, 1, 3141, 0,  0, -1);
    step(1,   0,  0, 0, 3141, 0,  0, -1);
    step(0, 305, 52, 1, 3141, 1,  7,  0);
    step(0, 105, 52, 1, 3141, 0,  0, -1);
    step(0, 331, 81, 1, 4095, 1, 13,  0);
    step(0, 332, 81, 1, 4095, 0,  0, -1);

    // frame_start during an active pixel: that pixel still uses the old shadow
    spr_x[9:0] = 10'd100;
    step(1, 105, 52, 1, 4095, 0,  0, -1);
    step(0, 105, 52, 1, 3141, 1,  7,  0);

    // Overlap: sprite 0 (198,198) f1 over sprite 2 (190,195) f5
    spr_en = 4'b0101;
    spr_x[9:0]   = 10'd198; spr_y[9:0]   = 10'd198; spr_frame[3:0]  = 4'd1;
    spr_x[29:20] = 10'd190; spr_y[29:20] = 10'd195; spr_frame[11:8] = 4'd5;
    step(1,   0,  0, 0, 3141, 0,  0, -1);
    step(0, 200, 200, 1, 1090, 0, 0,  0); // winner texel 0, no fall-through
    step(0, 201, 200, 1, 1091, 1, 1,  0);
    step(0, 190, 195, 1, 5120, 1, 2,  2);
    step(0, 195, 196, 1, 5157, 1, 7,  2);
    step(0, 225, 200, 1, 1115, 1, 9,  0);

    // Edges: sprite 1 at x=608 f0, sprite 3 at x=1020 (wraps) f2
    spr_en = 4'b1010;
    spr_x[19:10] = 10'd608;  spr_y[19:10] = 10'd0;  spr_frame[7:4]   = 4'd0;
    spr_x[39:30] = 10'd1020; spr_y[39:30] = 10'd10; spr_frame[15:12] = 4'd2;
    step(1,   0,  0, 0, 1115, 0,  0, -1);
    step(0, 639,  0, 1,   31, 1, 13,  1);
`ifdef SPR_COLLIDE_EN
    chk("collide_overlap_frame", int'(collide), 5);
`endif
    step(0, 640,  0, 1,   31, 0,  0, -1);
    step(0,   0, 10, 1, 2052, 1,  6,  3);
    step(0,  27, 10, 1, 2079, 1, 13,  3);
    step(0,  28, 10, 1, 2079, 0,  0, -1);
    step(0, 639,  0, 0,   31, 0,  0,  1);

    // Sprites 1 and 3 overlap at the single pixel (639,31)
    spr_x[39:30] = 10'd639; spr_y[39:30] = 10'd31;
    step(1,   0,  0, 0,   31, 0,  0, -1);
    step(0, 639, 31, 1, 1023, 1, 13,  1);
    step(1,   0,  0, 0, 1023, 0,  0, -1);
    step(0, 608,  0, 1,    0, 1,  2,  1);
`ifdef SPR_COLLIDE_EN
    chk("collide_set", int'(collide), 10);
`endif
    step(1,   0,  0, 0,    0, 0,  0, -1);
    step(0, 611,  3, 1,   99, 1,  1,  1);
`ifdef SPR_COLLIDE_EN
    chk("collide_cleared", int'(collide), 0);
`endif

    // Reset mid-line while the sprite is visible
    idle(5);
    chk("pre_reset pix_valid", int'(bus.pix_valid), 1);
    chk("pre_reset rom_addr", int'(bus.rom_addr), 99);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_reset_state("midline_reset");
    @(negedge clk) reset_n = 1'b1;
    step(0, 611,  3, 1,    0, 0,  0, -1); // shadows cleared: nothing drawn
    step(1,   0,  0, 0,    0, 0,  0, -1);
    step(0, 611,  3, 1,   99, 1,  1,  1);

    idle(6);
    chk("queues_drained", aq.size() + pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
